// File: rtl/random_multi_if.sv
// Request/response bundle for the multi-channel random source.
// The master side (game logic) drives requests and seeding. The slave side
// (random_multi) returns per-channel values and status.
interface random_multi_if #(
  parameter int SIZE_BITS = 8,
  parameter int NUM_CH    = 4
);
  logic [NUM_CH-1:0]           rise;
  logic [NUM_CH-1:0]           mode;
  logic                        seed_load;
  logic [15:0]                 seed_val;
  logic [NUM_CH*SIZE_BITS-1:0] dout;
  logic [NUM_CH-1:0]           valid;
  logic [NUM_CH-1:0]           busy;
  logic [NUM_CH-1:0]           fallback;

  modport master (
    output rise, mode, seed_load, seed_val,
    input  dout, valid, busy, fallback
  );

  modport slave (
    input  rise, mode, seed_load, seed_val,
    output dout, valid, busy, fallback
  );
endinterface

// File: rtl/random_multi.sv
// Multi-channel random number source.
// Each channel serves one request at a time, in one of two modes:
// - counter-latch: returns the shared counter value.
// - LFSR: runs rejection sampling on a per-channel rotation of the shared
//   LFSR. If no candidate is accepted within MAX_TRIES, the channel falls
//   back to the counter value.
// Every output stays within [MIN_VAL, MAX_VAL].
module random_multi #(
  parameter int          SIZE_BITS = 8,
  parameter int          NUM_CH    = 4,
  parameter int          MIN_VAL   = 0,
  parameter int          MAX_VAL   = 255,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           reset,
  random_multi_if.slave  bus
);

  localparam int                   TRY_W     = $clog2(MAX_TRIES) + 1;
  localparam logic [SIZE_BITS-1:0] MIN_V     = SIZE_BITS'(MIN_VAL);
  localparam logic [SIZE_BITS-1:0] MAX_V     = SIZE_BITS'(MAX_VAL);
  localparam logic [SIZE_BITS-1:0] RANGE     = SIZE_BITS'(MAX_VAL - MIN_VAL);
  localparam logic [SIZE_BITS-1:0] MID_V     = SIZE_BITS'((MIN_VAL + MAX_VAL) / 2);
  localparam logic [TRY_W-1:0]     LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [15:0]          SEED_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic {IDLE, SEARCH} state_t;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Channel candidate: low SIZE_BITS bits of the LFSR rotated left by 3*ch
  function automatic logic [SIZE_BITS-1:0] cand_of(input logic [15:0] s, input int ch);
    int          sh;
    logic [15:0] rot;
    sh  = (3 * ch) % 16;
    rot = (s << sh) | (s >> ((16 - sh) % 16));
    return SIZE_BITS'(rot);
  endfunction

  logic [SIZE_BITS-1:0] counter;
  logic [15:0]          lfsr;
  logic [NUM_CH-1:0]    rise_d;
  logic [NUM_CH-1:0]    req;
  logic [SIZE_BITS-1:0] cand   [NUM_CH];
  state_t               state  [NUM_CH];
  logic [TRY_W-1:0]     tries  [NUM_CH];
  logic [SIZE_BITS-1:0] dout_r [NUM_CH];
  logic [NUM_CH-1:0]    valid_r;
  logic [NUM_CH-1:0]    busy_r;
  logic [NUM_CH-1:0]    fb_r;

  assign req = bus.rise & ~rise_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign cand[g]                               = cand_of(lfsr, g);
    assign bus.dout[g*SIZE_BITS +: SIZE_BITS]    = dout_r[g];
  end

  assign bus.valid    = valid_r;
  assign bus.busy     = busy_r;
  assign bus.fallback = fb_r;

  // Shared wrap-around counter, shared LFSR (with seed load) and request edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= MIN_V;
      lfsr    <= SEED_INIT;
      rise_d  <= '0;
    end else begin
      counter <= (counter >= MAX_V) ? MIN_V : counter + SIZE_BITS'(1);
      if (bus.seed_load)
        lfsr <= (bus.seed_val == 16'h0000) ? 16'h0001 : bus.seed_val;
      else
        lfsr <= lfsr_next(lfsr);
      rise_d  <= bus.rise;
    end
  end

  // Independent per-channel request FSMs; edges seen while searching are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]  <= IDLE;
        tries[i]  <= '0;
        dout_r[i] <= MID_V;
      end
      valid_r <= '0;
      busy_r  <= '0;
      fb_r    <= '0;
    end else begin
      valid_r <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (req[i]) begin
              if (bus.mode[i]) begin
                state[i]  <= SEARCH;
                busy_r[i] <= 1'b1;
                tries[i]  <= '0;
              end else begin
                dout_r[i]  <= counter;
                valid_r[i] <= 1'b1;
                fb_r[i]    <= 1'b0;
              end
            end
          end
          SEARCH: begin
            if (cand[i] <= RANGE) begin
              dout_r[i]  <= MIN_V + cand[i];
              valid_r[i] <= 1'b1;
              fb_r[i]    <= 1'b0;
              busy_r[i]  <= 1'b0;
              state[i]   <= IDLE;
            end else if (tries[i] == LAST_TRY) begin
              dout_r[i]  <= counter;
              valid_r[i] <= 1'b1;
              fb_r[i]    <= 1'b1;
              busy_r[i]  <= 1'b0;
              state[i]   <= IDLE;
            end else begin
              tries[i] <= tries[i] + TRY_W'(1);
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_random_multi.sv
// Bench for random_multi. It runs two instances with different parameters
// from the same stimulus:
// - a full-range 8-bit instance, where every LFSR candidate is accepted;
// - a narrow 4-bit instance (3..9, two tries), where rejections and the
//   counter fallback occur.
// A reference model derives every expected output from the request rules.
module tb_random_multi;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NCH-1:0] rise = '0;
  logic [NCH-1:0] mode = '0;
  logic           seed_load = 1'b0;
  logic [15:0]    seed_val = 16'h0;

  initial forever #5 clk = ~clk;

  random_multi_if #(.SIZE_BITS(8), .NUM_CH(NCH)) bus_f ();
  random_multi_if #(.SIZE_BITS(4), .NUM_CH(NCH)) bus_n ();

  assign bus_f.rise = rise;      assign bus_n.rise = rise;
  assign bus_f.mode = mode;      assign bus_n.mode = mode;
  assign bus_f.seed_load = seed_load; assign bus_n.seed_load = seed_load;
  assign bus_f.seed_val = seed_val;   assign bus_n.seed_val = seed_val;

  random_multi #(.SIZE_BITS(8), .NUM_CH(NCH), .MIN_VAL(0), .MAX_VAL(255),
                 .MAX_TRIES(8), .LFSR_SEED(16'hACE1))
    u_full (.clk(clk), .reset(reset), .bus(bus_f));

  random_multi #(.SIZE_BITS(4), .NUM_CH(NCH), .MIN_VAL(3), .MAX_VAL(9),
                 .MAX_TRIES(2), .LFSR_SEED(16'hACE1))
    u_narrow (.clk(clk), .reset(reset), .bus(bus_n));

  int p_min   [2] = '{0, 3};
  int p_max   [2] = '{255, 9};
  int p_tries [2] = '{8, 2};
  int p_sb    [2] = '{8, 4};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int dut_dout(input int d, input int i);
    if (d == 0) return int'(bus_f.dout[i*8 +: 8]);
    return int'(bus_n.dout[i*4 +: 4]);
  endfunction
  function automatic int dut_valid(input int d, input int i);
    return (d == 0) ? int'(bus_f.valid[i]) : int'(bus_n.valid[i]);
  endfunction
  function automatic int dut_busy(input int d, input int i);
    return (d == 0) ? int'(bus_f.busy[i]) : int'(bus_n.busy[i]);
  endfunction
  function automatic int dut_fb(input int d, input int i);
    return (d == 0) ? int'(bus_f.fallback[i]) : int'(bus_n.fallback[i]);
  endfunction

  // ---------------- reference model ----------------
  int             m_n;                 // clock edges since reset release
  logic [15:0]    m_lfsr;
  logic [NCH-1:0] m_rise_prev;
  bit             m_pend   [2][NCH];
  int             m_t      [2][NCH];   // edge index at which the request was taken
  int             exp_dout [2][NCH];
  bit             exp_valid[2][NCH];
  bit             exp_busy [2][NCH];
  bit             exp_fb   [2][NCH];

  function automatic logic [15:0] poly_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  function automatic int cand_model(input logic [15:0] l, input int ch, input int sb);
    logic [15:0] rot;
    int s;
    s = (3 * ch) % 16;
    for (int b = 0; b < 16; b++) rot[(b + s) % 16] = l[b];
    return int'(rot) % (1 << sb);
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_lfsr = 16'hACE1;
    m_rise_prev = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        m_pend[d][i] = 0; m_t[d][i] = 0;
        exp_dout[d][i] = (p_min[d] + p_max[d]) / 2;
        exp_valid[d][i] = 0; exp_busy[d][i] = 0; exp_fb[d][i] = 0;
      end
  endtask

  task automatic deliver(input int d, input int i, input int v, input bit fb);
    exp_dout[d][i] = v; exp_valid[d][i] = 1; exp_fb[d][i] = fb; m_pend[d][i] = 0;
  endtask

  task automatic model_step();
    int cnt, cand, k;
    for (int d = 0; d < 2; d++) begin
      cnt = p_min[d] + (m_n % (p_max[d] - p_min[d] + 1));
      for (int i = 0; i < NCH; i++) begin
        exp_valid[d][i] = 0;
        if (m_pend[d][i]) begin
          k = m_n - m_t[d][i];
          cand = cand_model(m_lfsr, i, p_sb[d]);
          if (cand <= p_max[d] - p_min[d]) deliver(d, i, p_min[d] + cand, 0);
          else if (k == p_tries[d]) deliver(d, i, cnt, 1);
        end else if (rise[i] && !m_rise_prev[i]) begin
          if (mode[i]) begin m_pend[d][i] = 1; m_t[d][i] = m_n; end
          else deliver(d, i, cnt, 0);
        end
        exp_busy[d][i] = m_pend[d][i];
      end
    end
    m_rise_prev = rise;
    m_lfsr = seed_load ? ((seed_val == 16'h0) ? 16'h0001 : seed_val) : poly_step(m_lfsr);
    m_n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs of both instances
  initial forever begin
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("model d%0d ch%0d dout", d, i), dut_dout(d, i), exp_dout[d][i]);
        check($sformatf("model d%0d ch%0d valid", d, i), dut_valid(d, i), int'(exp_valid[d][i]));
        check($sformatf("model d%0d ch%0d busy", d, i), dut_busy(d, i), int'(exp_busy[d][i]));
        check($sformatf("model d%0d ch%0d fallback", d, i), dut_fb(d, i), int'(exp_fb[d][i]));
      end
  end

  // ---------------- stimulus with hand-computed pins ----------------
  int wrap_exp [7] = '{5, 7, 9, 4, 6, 8, 3};
  int reset_hold = 0;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      check("reset full dout", dut_dout(0, i), 127);
      check("reset narrow dout", dut_dout(1, i), 6);
    end
    check("reset valid", int'(bus_f.valid | bus_n.valid), 0);
    check("reset busy", int'(bus_f.busy | bus_n.busy), 0);
    reset = 1'b0;

    // Counter latch at counter = 0x2A (edge 42 after release)
    repeat (42) @(posedge clk);
    @(negedge clk); rise[0] = 1'b1;
    @(posedge clk); #3;
    check("cnt full dout0", dut_dout(0, 0), 42);
    check("cnt full valid0", int'(bus_f.valid[0]), 1);
    check("cnt full busy0", int'(bus_f.busy[0]), 0);
    check("cnt narrow dout0", dut_dout(1, 0), 3);

    // Repeated counter requests every other edge on the narrow 3..9 counter
    for (int j = 0; j < 7; j++) begin
      @(negedge clk); rise[0] = 1'b0;
      @(negedge clk); rise[0] = 1'b1;
      @(posedge clk); #3;
      check("wrap narrow dout0", dut_dout(1, 0), wrap_exp[j]);
    end
    @(negedge clk); rise[0] = 1'b0;

    // seed_val = 0 loads 0x0001; one step later 0x0002; ch1 rot3 -> 0x10
    @(negedge clk); seed_load = 1'b1; seed_val = 16'h0000;
    @(negedge clk); seed_load = 1'b0; rise[1] = 1'b1; mode[1] = 1'b1;
    @(posedge clk); #3;
    check("lfsr full busy1", int'(bus_f.busy[1]), 1);
    check("lfsr full valid1 early", int'(bus_f.valid[1]), 0);
    @(posedge clk); #3;
    check("lfsr full dout1", dut_dout(0, 1), 16);
    check("lfsr full valid1", int'(bus_f.valid[1]), 1);
    check("lfsr full fb1", int'(bus_f.fallback[1]), 0);
    check("lfsr full busy1 drop", int'(bus_f.busy[1]), 0);
    check("lfsr narrow dout1", dut_dout(1, 1), 3);
    @(negedge clk); rise[1] = 1'b0;

    // Simultaneous LFSR requests: seed 0x8000 steps to 0x0001
    @(negedge clk); seed_load = 1'b1; seed_val = 16'h8000;
    @(negedge clk); seed_load = 1'b0; mode = 4'b1111; rise = 4'b1111;
    @(posedge clk); #3;
    check("sim full busy", int'(bus_f.busy), 15);
    @(negedge clk); rise[1] = 1'b0;
    @(posedge clk); #3;
    check("sim full valid", int'(bus_f.valid), 15);
    check("sim full dout0", dut_dout(0, 0), 8'h01);
    check("sim full dout1", dut_dout(0, 1), 8'h08);
    check("sim full dout2", dut_dout(0, 2), 8'h40);
    check("sim full dout3", dut_dout(0, 3), 8'h00);
    check("sim narrow dout0", dut_dout(1, 0), 4);
    check("sim narrow busy1", int'(bus_n.busy[1]), 1);
    @(negedge clk); rise[1] = 1'b1;   // arrives while narrow ch1 still searching
    @(posedge clk); #3;
    check("sim narrow valid1", int'(bus_n.valid[1]), 1);
    check("sim narrow dout1", dut_dout(1, 1), 3);
    @(posedge clk); #3;
    check("drop narrow busy1", int'(bus_n.busy[1]), 0);
    check("drop narrow valid1", int'(bus_n.valid[1]), 0);
    @(negedge clk); rise = '0;

    // Fallback: seed 0x8007 -> 0x000F -> 0x001E, narrow rejects both
    @(negedge clk); seed_load = 1'b1; seed_val = 16'h8007;
    @(negedge clk); seed_load = 1'b0; rise[0] = 1'b1;
    @(posedge clk); #3;
    check("fb narrow busy0 t", int'(bus_n.busy[0]), 1);
    @(posedge clk); #3;
    check("fb narrow busy0 t1", int'(bus_n.busy[0]), 1);
    check("fb full dout0", dut_dout(0, 0), 8'h0F);
    @(posedge clk); #3;
    check("fb narrow valid0", int'(bus_n.valid[0]), 1);
    check("fb narrow fallback0", int'(bus_n.fallback[0]), 1);
    check("fb narrow in range", int'(dut_dout(1, 0) >= 3 && dut_dout(1, 0) <= 9), 1);

    // Reset during a narrow search
    @(negedge clk); rise[0] = 1'b0; seed_load = 1'b1; seed_val = 16'h8007;
    @(negedge clk); seed_load = 1'b0; rise[0] = 1'b1;
    @(posedge clk); #3;
    check("rst narrow busy0 before", int'(bus_n.busy[0]), 1);
    @(negedge clk); reset = 1'b1; rise[0] = 1'b0;
    #1;
    check("rst narrow busy0", int'(bus_n.busy[0]), 0);
    check("rst narrow fallback0", int'(bus_n.fallback[0]), 0);
    check("rst narrow valid0", int'(bus_n.valid[0]), 0);
    check("rst narrow dout0", dut_dout(1, 0), 6);
    check("rst full dout0", dut_dout(0, 0), 127);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk); #3;
    check("rst no late valid", int'(bus_n.valid[0]), 0);
    check("rst dout held", dut_dout(1, 0), 6);

    // Randomized traffic with occasional seeding and resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (reset_hold > 0) begin
        reset_hold--;
        if (reset_hold == 0) reset = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        reset_hold = int'($urandom_range(1, 3));
      end
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 2) == 0) rise[i] = ~rise[i];
      mode = 4'($urandom);
      seed_load = ($urandom_range(0, 15) == 0);
      seed_val = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
    end
    @(negedge clk); reset = 1'b0; rise = '0; seed_load = 1'b0;
    repeat (12) @(posedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
